// File: rtl/led_scan_ctrl_pkg.sv
// Shared definitions for the LED matrix scan controller.
// Holds the scan FSM state encoding, the default matrix geometry, the row/column
// word types and the "all LEDs off" drive levels (rows active-high, columns
// active-low).
package led_pkg;

    localparam int LED_ROWS  = 8;
    localparam int LED_COLS  = 8;
    localparam int ROW_IDX_W = $clog2(LED_ROWS);

    typedef logic [LED_ROWS-1:0]  row_t;
    typedef logic [LED_COLS-1:0]  col_t;
    typedef logic [ROW_IDX_W-1:0] ridx_t;

    localparam row_t LED_ROW_OFF = '0;
    localparam col_t LED_COL_OFF = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_ON
    } scan_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_scan_ctrl_if.sv
// CPU/matrix-side signal bundle of the LED scan controller.
//   enable      : scanning runs while high
//   wr_en/addr/data : row write into the back bank (bit=1 means LED on)
//   swap_req/ack: level request / one-cycle acknowledge of a bank swap
//   led_row     : one-hot row drive, active-high
//   led_col     : column drive, active-low
//   row_idx     : row currently lit or about to be lit
//   frame_start : pulse when row 0 of a frame lights
// master = CPU/bench side, slave = controller side.
interface led_scan_ctrl_if;
    import led_pkg::*;

    logic  enable;
    logic  wr_en;
    ridx_t wr_addr;
    col_t  wr_data;
    logic  swap_req;
    logic  swap_ack;
    row_t  led_row;
    col_t  led_col;
    ridx_t row_idx;
    logic  frame_start;

    modport master (
        output enable, wr_en, wr_addr, wr_data, swap_req,
        input  swap_ack, led_row, led_col, row_idx, frame_start
    );

    modport slave (
        input  enable, wr_en, wr_addr, wr_data, swap_req,
        output swap_ack, led_row, led_col, row_idx, frame_start
    );

endinterface

// File: rtl/led_scan_ctrl_frame_buf.sv
// Double-buffered frame store for the LED matrix.
//   clk, reset_n : clock, async active-low reset (clears both banks, front=0)
//   flip_i       : swap front and back banks on this edge
//   wr_en_i, wr_addr_i, wr_data_i : write port into the back bank
//   rd_addr_i, rd_data_o          : combinational read of the front bank
module led_frame_buf
    import led_pkg::*;
#(
    parameter int ROWS = LED_ROWS,
    parameter int COLS = LED_COLS
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flip_i,
    input  logic                    wr_en_i,
    input  logic [$clog2(ROWS)-1:0] wr_addr_i,
    input  logic [COLS-1:0]         wr_data_i,
    input  logic [$clog2(ROWS)-1:0] rd_addr_i,
    output logic [COLS-1:0]         rd_data_o
);

    logic            front_q;
    logic [COLS-1:0] mem_q [2][ROWS];

    // The write bank is taken from front_q before this edge's flip, so a write
    // that coincides with a swap lands in the bank that becomes visible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            front_q <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    mem_q[b][r] <= '0;
                end
            end
        end else begin
            if (wr_en_i) begin
                mem_q[~front_q][wr_addr_i] <= wr_data_i;
            end
            if (flip_i) begin
                front_q <= ~front_q;
            end
        end
    end

    assign rd_data_o = mem_q[front_q][rd_addr_i];

endmodule

// File: rtl/led_scan_ctrl.sv
// Row-scanning refresh controller for an LED matrix with a double-buffered
// frame store. Each row is preceded by BLANK dark cycles and then lit for
// DWELL cycles; bank swaps are only taken at a frame boundary or while idle.
//   clk, reset_n : clock, async active-low reset (outputs blank at once)
//   bus          : led_scan_ctrl_if.slave (write port, swap handshake,
//                  row/column drive, row index, frame_start)
module led_scan_ctrl
    import led_pkg::*;
#(
    parameter int ROWS  = LED_ROWS,
    parameter int COLS  = LED_COLS,
    parameter int DWELL = 1000,
    parameter int BLANK = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    led_scan_ctrl_if.slave bus
);

    localparam int               CNT_W      = max2(1, $clog2(max2(DWELL, BLANK)));
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
    localparam ridx_t            ROW_LAST   = ridx_t'(ROWS - 1);

    scan_state_t      state_q;
    logic [CNT_W-1:0] cnt_q;
    ridx_t            row_idx_q;
    row_t             led_row_q;
    col_t             led_col_q;
    logic             swap_ack_q;
    logic             frame_start_q;

    logic             frame_end;
    logic             swap_d;
    col_t             front_row;

    // Last ON cycle of the last row; a disable on that edge takes priority.
    assign frame_end = (state_q == ST_ON) && bus.enable &&
                       (cnt_q == DWELL_LAST) && (row_idx_q == ROW_LAST);

    // The ack cycle masks the request so a requester that drops swap_req one
    // cycle after seeing the ack does not trigger a second flip while idle.
    assign swap_d = bus.swap_req && !swap_ack_q &&
                    ((state_q == ST_IDLE) || frame_end);

    led_frame_buf #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_frame_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .flip_i    (swap_d),
        .wr_en_i   (bus.wr_en),
        .wr_addr_i (bus.wr_addr),
        .wr_data_i (bus.wr_data),
        .rd_addr_i (row_idx_q),
        .rd_data_o (front_row)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            row_idx_q     <= '0;
            led_row_q     <= LED_ROW_OFF;
            led_col_q     <= LED_COL_OFF;
            swap_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            swap_ack_q    <= swap_d;
            frame_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q     <= '0;
                    row_idx_q <= '0;
                    led_row_q <= LED_ROW_OFF;
                    led_col_q <= LED_COL_OFF;
                    if (bus.enable) begin
                        state_q <= ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    if (!bus.enable) begin
                        state_q   <= ST_IDLE;
                        cnt_q     <= '0;
                        row_idx_q <= '0;
                        led_row_q <= LED_ROW_OFF;
                        led_col_q <= LED_COL_OFF;
                    end else if (cnt_q == BLANK_LAST) begin
                        // Latch the row pattern here so later writes never
                        // disturb the row while it is lit.
                        state_q       <= ST_ON;
                        cnt_q         <= '0;
                        led_row_q     <= row_t'(1) << row_idx_q;
                        led_col_q     <= ~front_row;
                        frame_start_q <= (row_idx_q == '0);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_ON: begin
                    if (!bus.enable) begin
                        state_q   <= ST_IDLE;
                        cnt_q     <= '0;
                        row_idx_q <= '0;
                        led_row_q <= LED_ROW_OFF;
                        led_col_q <= LED_COL_OFF;
                    end else if (cnt_q == DWELL_LAST) begin
                        state_q   <= ST_BLANK;
                        cnt_q     <= '0;
                        led_row_q <= LED_ROW_OFF;
                        led_col_q <= LED_COL_OFF;
                        row_idx_q <= (row_idx_q == ROW_LAST) ? '0 : row_idx_q + ridx_t'(1);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    cnt_q     <= '0;
                    row_idx_q <= '0;
                    led_row_q <= LED_ROW_OFF;
                    led_col_q <= LED_COL_OFF;
                end
            endcase
        end
    end

    assign bus.swap_ack    = swap_ack_q;
    assign bus.led_row     = led_row_q;
    assign bus.led_col     = led_col_q;
    assign bus.row_idx     = row_idx_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: doc/led_scan_ctrl.md
Name: led_scan_ctrl

Overview:
- Refresh controller for the 8x8 LED matrix; owns a double-buffered frame store and drives the matrix row/column lines directly.
- Scans one row at a time with a programmable dwell, and inserts a blanking gap between rows to suppress ghosting.
- The CPU-side writer fills the back bank through a simple write port. A swap handshake flips banks only at a frame boundary, so no frame ever tears.

Parameters:
- ROWS, 8, number of matrix rows scanned.
- COLS, 8, number of columns (width of one row word).
- DWELL, 1000, clk cycles a row stays lit (>=1).
- BLANK, 16, clk cycles all LEDs are off between rows (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  scanning runs while 1.
- wr_en  in  1  write strobe into the back bank.
- wr_addr  in  3  row index written.
- wr_data  in  8  row pattern, bit=1 means LED on.
- swap_req  in  1  level request to make the back bank visible; hold until swap_ack.
- swap_ack  out  1  one-cycle pulse when the swap has taken effect.
- led_row  out  8  one-hot row drive, active-high.
- led_col  out  8  column drive, active-low (~pattern).
- row_idx  out  3  row currently lit or about to be lit.
- frame_start  out  1  one-cycle pulse on entering ON for row 0.

Behaviour:
- Reset (async assert, sync release) sets the following:
  - led_row=8'h00, led_col=8'hFF, row_idx=0, swap_ack=0, frame_start=0.
  - front bank=0, both banks cleared to 8'h00, state=IDLE, counters=0.
- All outputs are registered.
- States:
  - IDLE: outputs are blanked (led_row=0, led_col=FF).
    - Goes to BLANK on the cycle enable is seen as 1.
  - BLANK: outputs blanked; counts BLANK cycles.
    - On the last count it goes to ON and loads led_row=1<<row_idx and led_col=~front[row_idx].
  - ON: outputs held constant; counts DWELL cycles.
    - On the last count, outputs are blanked and the FSM goes to BLANK.
    - If row_idx==ROWS-1, row_idx wraps to 0 and a frame boundary occurs; otherwise row_idx increments.
- Row timing: the period of one row is BLANK+DWELL cycles, and one frame is ROWS*(BLANK+DWELL).
- The counter width is clog2(max(DWELL,BLANK)). The counter resets to 0 on every state entry.
- frame_start pulses in the same cycle that led_row first becomes 8'h01 in a frame.
- Swap:
  - Swap triggers at a frame boundary, or on any cycle in IDLE, if swap_req=1.
  - The front bank flips and swap_ack pulses high for exactly one cycle, in the cycle after the flip.
  - If swap_req is still high after the ack, it is treated as a new request and is served at the next boundary.
  - swap_req=0 at a boundary means no flip.
- Writes:
  - A write always targets the current back bank, and the bank select is sampled before any same-cycle swap.
  - A write coincident with a swap therefore lands in the bank that becomes front.
  - Writes never affect the row currently lit.
- Disable: enable=0 in BLANK or ON moves to IDLE on the next edge.
  - Outputs are blanked in that same edge, and row_idx is forced to 0.
  - Re-enable starts a fresh frame from BLANK, row 0.
- Reset mid-operation:
  - Outputs go blank immediately (asynchronously).
  - Any pending swap is discarded and the buffer contents are cleared.
- Invariants (bench must check):
  - led_row is always either 0 or one-hot.
  - led_row=0 always implies led_col=FF.
  - led_row is never non-zero in IDLE or BLANK.

Decomposition:
- Shared package led_pkg holds:
  - the state enum {IDLE, BLANK, ON};
  - ROWS/COLS defaults;
  - LED_ROW_OFF=8'h00 and LED_COL_OFF=8'hFF.
- Sub-module led_frame_buf contains:
  - the 2 x ROWS x COLS register store;
  - one write port into the back bank;
  - one async read port from the front bank;
  - a bank-select flip input.
- The FSM, counters, and swap logic stay in led_scan_ctrl.

Test Plan:
- Reset and idle: assert reset_n=0 mid-scan -> led_row=00, led_col=FF, swap_ack=0 immediately. With enable=0 these hold indefinitely.
- Basic scan (DWELL=4, BLANK=2): preload rows 0..7 with 8'h01<<i via write+swap in IDLE, then enable=1.
  - Row 0 lights 2 cycles after enable, with led_row=01, led_col=FE held for 4 cycles.
  - 2 blank cycles follow, then row 1 (led_row=02, led_col=FD).
  - frame_start repeats every 48 cycles.
- Swap at boundary: write back bank rows=8'hAA and raise swap_req mid-frame.
  - Nothing changes until row 7 ends; swap_ack pulses once.
  - The next row 0 shows led_col=8'h55.
  - Drop swap_req after the ack -> no further ack.
- Write/swap collision: wr_en on the same edge as the boundary swap, wr_addr=3, wr_data=8'hF0 -> row 3 of the new front frame shows led_col=8'h0F.
- Enable drop mid-row: deassert enable during ON of row 5 -> next cycle led_row=00, led_col=FF, row_idx=0. Re-enable -> row 0 lights after BLANK cycles.
- Invariant sweep: random writes, swaps, enable toggles, and resets over 10k cycles -> led_row always 0 or one-hot, and led_col=FF whenever led_row=0.
